// File: rtl/hazard_pipe_ctrl_if.sv
// Bundle between the decode stage and the hazard/pipeline-tracking controller.
// The decode/control side (master) drives the ID instruction fields and the
// flush/freeze controls; the controller (slave) returns the tracked pipeline
// register fields and the PC / IF-ID enables.
interface hazard_pipe_ctrl_if;
  // decode-stage instruction fields
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_uses_rt;
  // pipeline controls
  logic        flush_i;
  logic        mem_stall_i;
  // tracked pipeline register fields
  logic [4:0]  ID_EX_Rs;
  logic [4:0]  ID_EX_Rt;
  logic [4:0]  ID_EX_Rd;
  logic        ID_EX_RegWrite;
  logic        ID_EX_MemRead;
  logic [4:0]  EX_MEM_Rd;
  logic        EX_MEM_RegWrite;
  logic [4:0]  MEM_WB_Rd;
  logic        MEM_WB_RegWrite;
  // pipeline control outputs
  logic        pc_write;
  logic        if_id_write;
  logic        bubble_o;
  logic [15:0] stall_count;

  modport master (
    output id_rs, id_rt, id_rd, id_regwrite, id_memread, id_uses_rt,
    output flush_i, mem_stall_i,
    input  ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead,
    input  EX_MEM_Rd, EX_MEM_RegWrite, MEM_WB_Rd, MEM_WB_RegWrite,
    input  pc_write, if_id_write, bubble_o, stall_count
  );

  modport slave (
    input  id_rs, id_rt, id_rd, id_regwrite, id_memread, id_uses_rt,
    input  flush_i, mem_stall_i,
    output ID_EX_Rs, ID_EX_Rt, ID_EX_Rd, ID_EX_RegWrite, ID_EX_MemRead,
    output EX_MEM_Rd, EX_MEM_RegWrite, MEM_WB_Rd, MEM_WB_RegWrite,
    output pc_write, if_id_write, bubble_o, stall_count
  );
endinterface

// File: rtl/hazard_pipe_ctrl.sv
// Load-use hazard detection and pipeline-register tracking for a 5-stage
// in-order pipeline. Tracks the register fields of ID/EX, EX/MEM and MEM/WB,
// and decides each cycle between freeze (memory busy), bubble (flush or
// load-use) and normal advance. Load-use stalls are counted (saturating).
module hazard_pipe_ctrl (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_pipe_ctrl_if.slave  bus
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } idex_t;

  typedef struct packed {
    logic [4:0] rd;
    logic       regwrite;
  } wbtrk_t;

  // Per-edge action, in priority order: freeze beats flush beats load-use.
  typedef enum logic [1:0] {
    ACT_ADV   = 2'd0,
    ACT_HOLD  = 2'd1,
    ACT_FLUSH = 2'd2,
    ACT_LU    = 2'd3
  } act_e;

  localparam idex_t  IDEX_ZERO = '0;

  idex_t       idex_q,   idex_d;
  wbtrk_t      exmem_q,  exmem_d;
  wbtrk_t      memwb_q,  memwb_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        rd_nz;
  logic        hit_rs;
  logic        hit_rt;
  logic        lu;
  act_e        act;
  logic        pc_write;
  logic        if_id_write;
  logic        bubble;

  // Load-use detect: only from registered ID/EX state and current ID fields,
  // so nothing loops back from pc_write. $0 never matches.
  always_comb begin
    rd_nz  = (idex_q.rd != 5'd0);
    hit_rs = (idex_q.rd == bus.id_rs);
    hit_rt = bus.id_uses_rt && (idex_q.rd == bus.id_rt);
    lu     = idex_q.memread && rd_nz && (hit_rs || hit_rt);
  end

  // Action select in priority order.
  always_comb begin
    act = ACT_ADV;
    if (bus.mem_stall_i)  act = ACT_HOLD;
    else if (bus.flush_i) act = ACT_FLUSH;
    else if (lu)          act = ACT_LU;
  end

  // Next-state and control outputs; default is a full freeze.
  always_comb begin
    idex_d      = idex_q;
    exmem_d     = exmem_q;
    memwb_d     = memwb_q;
    stall_cnt_d = stall_cnt_q;
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    bubble      = 1'b0;
    case (act)
      ACT_HOLD: begin
        // everything keeps its value
      end
      ACT_FLUSH: begin
        // flush squashes the ID instruction but fetch keeps going toward the
        // branch target, so PC and IF/ID still update
        idex_d      = IDEX_ZERO;
        exmem_d     = '{rd: idex_q.rd, regwrite: idex_q.regwrite};
        memwb_d     = exmem_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        bubble      = 1'b1;
      end
      ACT_LU: begin
        // hold IF/ID and PC, drop a bubble behind the load; the zeroed ID/EX
        // clears lu next cycle so a single hazard costs exactly one cycle
        idex_d      = IDEX_ZERO;
        exmem_d     = '{rd: idex_q.rd, regwrite: idex_q.regwrite};
        memwb_d     = exmem_q;
        bubble      = 1'b1;
        if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      end
      default: begin
        idex_d      = '{rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd,
                        regwrite: bus.id_regwrite, memread: bus.id_memread};
        exmem_d     = '{rd: idex_q.rd, regwrite: idex_q.regwrite};
        memwb_d     = exmem_q;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    endcase
  end

  // Pipeline tracking registers and stall counter, async clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idex_q      <= IDEX_ZERO;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= exmem_d;
      memwb_q     <= memwb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.ID_EX_Rs        = idex_q.rs;
  assign bus.ID_EX_Rt        = idex_q.rt;
  assign bus.ID_EX_Rd        = idex_q.rd;
  assign bus.ID_EX_RegWrite  = idex_q.regwrite;
  assign bus.ID_EX_MemRead   = idex_q.memread;
  assign bus.EX_MEM_Rd       = exmem_q.rd;
  assign bus.EX_MEM_RegWrite = exmem_q.regwrite;
  assign bus.MEM_WB_Rd       = memwb_q.rd;
  assign bus.MEM_WB_RegWrite = memwb_q.regwrite;
  assign bus.pc_write        = pc_write;
  assign bus.if_id_write     = if_id_write;
  assign bus.bubble_o        = bubble;
  assign bus.stall_count     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed bench for hazard_pipe_ctrl. The driver applies one vector per
// cycle just after the rising edge and queues the hand-computed response for
// that cycle; the monitor pops and compares on the falling edge.
module tb_hazard_pipe_ctrl;

  typedef struct {
    int          id;
    logic        pc, ifid, bub;
    logic [4:0]  irs, irt, ird;
    logic        irw, imr;
    logic [4:0]  erd;
    logic        erw;
    logic [4:0]  wrd;
    logic        wrw;
    logic [15:0] cnt;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;
  exp_t sb[$];

  hazard_pipe_ctrl_if bus();

  hazard_pipe_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic exp_t E(logic pc, logic ifid, logic bub,
                             logic [4:0] irs, logic [4:0] irt, logic [4:0] ird,
                             logic irw, logic imr,
                             logic [4:0] erd, logic erw,
                             logic [4:0] wrd, logic wrw,
                             logic [15:0] cnt);
    exp_t e;
    e.id = 0; e.pc = pc; e.ifid = ifid; e.bub = bub;
    e.irs = irs; e.irt = irt; e.ird = ird; e.irw = irw; e.imr = imr;
    e.erd = erd; e.erw = erw; e.wrd = wrd; e.wrw = wrw; e.cnt = cnt;
    return e;
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL step%0d %s got=%0h exp=%0h", id, nm, got, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic urt,
                      input logic fl, input logic ms, input exp_t e);
    exp_t x;
    @(posedge clk_i);
    #1;
    rst_i           = r;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
    bus.id_regwrite = rw;
    bus.id_memread  = mr;
    bus.id_uses_rt  = urt;
    bus.flush_i     = fl;
    bus.mem_stall_i = ms;
    x    = e;
    x.id = step_id;
    step_id++;
    sb.push_back(x);
  endtask

  // monitor: one queued response per cycle, compared mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc_write",        e.id, 16'(bus.pc_write),        16'(e.pc));
        chk("if_id_write",     e.id, 16'(bus.if_id_write),     16'(e.ifid));
        chk("bubble_o",        e.id, 16'(bus.bubble_o),        16'(e.bub));
        chk("ID_EX_Rs",        e.id, 16'(bus.ID_EX_Rs),        16'(e.irs));
        chk("ID_EX_Rt",        e.id, 16'(bus.ID_EX_Rt),        16'(e.irt));
        chk("ID_EX_Rd",        e.id, 16'(bus.ID_EX_Rd),        16'(e.ird));
        chk("ID_EX_RegWrite",  e.id, 16'(bus.ID_EX_RegWrite),  16'(e.irw));
        chk("ID_EX_MemRead",   e.id, 16'(bus.ID_EX_MemRead),   16'(e.imr));
        chk("EX_MEM_Rd",       e.id, 16'(bus.EX_MEM_Rd),       16'(e.erd));
        chk("EX_MEM_RegWrite", e.id, 16'(bus.EX_MEM_RegWrite), 16'(e.erw));
        chk("MEM_WB_Rd",       e.id, 16'(bus.MEM_WB_Rd),       16'(e.wrd));
        chk("MEM_WB_RegWrite", e.id, 16'(bus.MEM_WB_RegWrite), 16'(e.wrw));
        chk("stall_count",     e.id, bus.stall_count,          e.cnt);
      end
    end
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_regwrite = 1'b0; bus.id_memread = 1'b0; bus.id_uses_rt = 1'b0;
    bus.flush_i = 1'b0; bus.mem_stall_i = 1'b0;

    // reset state, then release with a NOP
    step(1, 0,0,0,   0,0,0, 0,0, E(1,1,0, 0,0,0,0,0, 0,0, 0,0, 16'h0000));
    step(0, 0,0,0,   0,0,0, 0,0, E(1,1,0, 0,0,0,0,0, 0,0, 0,0, 16'h0000));
    // lw $8 then add using $8 as rs: one stall, then bubble visible in ID/EX
    step(0, 1,0,8,   1,1,0, 0,0, E(1,1,0, 0,0,0,0,0, 0,0, 0,0, 16'h0000));
    step(0, 8,2,10,  1,0,1, 0,0, E(0,0,1, 1,0,8,1,1, 0,0, 0,0, 16'h0000));
    step(0, 8,2,10,  1,0,1, 0,0, E(1,1,0, 0,0,0,0,0, 8,1, 0,0, 16'h0001));
    // load $9, rt=9 consumer without rt use: no stall
    step(0, 1,0,9,   1,1,0, 0,0, E(1,1,0, 8,2,10,1,0, 0,0, 8,1, 16'h0001));
    step(0, 4,9,11,  1,0,0, 0,0, E(1,1,0, 1,0,9,1,1, 10,1, 0,0, 16'h0001));
    // load $9, rt=9 consumer that uses rt: one stall
    step(0, 1,0,9,   1,1,0, 0,0, E(1,1,0, 4,9,11,1,0, 9,1, 10,1, 16'h0001));
    step(0, 4,9,12,  1,0,1, 0,0, E(0,0,1, 1,0,9,1,1, 11,1, 9,1, 16'h0001));
    step(0, 4,9,12,  1,0,1, 0,0, E(1,1,0, 0,0,0,0,0, 9,1, 11,1, 16'h0002));
    // load to $0 then rs=0, rt=0: never a hazard
    step(0, 1,0,0,   1,1,0, 0,0, E(1,1,0, 4,9,12,1,0, 0,0, 9,1, 16'h0002));
    step(0, 0,0,13,  1,0,1, 0,0, E(1,1,0, 1,0,0,1,1, 12,1, 0,0, 16'h0002));
    // flush in the same cycle as a load-use hazard
    step(0, 2,0,7,   1,1,0, 0,0, E(1,1,0, 0,0,13,1,0, 0,1, 12,1, 16'h0002));
    step(0, 7,3,14,  1,0,1, 1,0, E(1,1,1, 2,0,7,1,1, 13,1, 0,1, 16'h0002));
    step(0, 0,0,0,   0,0,0, 0,0, E(1,1,0, 0,0,0,0,0, 7,1, 13,1, 16'h0002));
    // build EX_MEM_Rd=5 / MEM_WB_Rd=3, then freeze for 3 cycles
    step(0, 1,2,3,   1,0,1, 0,0, E(1,1,0, 0,0,0,0,0, 0,0, 7,1, 16'h0002));
    step(0, 1,2,5,   1,0,1, 0,0, E(1,1,0, 1,2,3,1,0, 0,0, 0,0, 16'h0002));
    step(0, 3,5,6,   1,0,1, 0,0, E(1,1,0, 1,2,5,1,0, 3,1, 0,0, 16'h0002));
    step(0, 6,0,15,  1,1,0, 0,1, E(0,0,0, 3,5,6,1,0, 5,1, 3,1, 16'h0002));
    step(0, 6,0,15,  1,1,0, 0,1, E(0,0,0, 3,5,6,1,0, 5,1, 3,1, 16'h0002));
    step(0, 6,0,15,  1,1,0, 0,1, E(0,0,0, 3,5,6,1,0, 5,1, 3,1, 16'h0002));
    step(0, 6,0,15,  1,1,0, 0,0, E(1,1,0, 3,5,6,1,0, 5,1, 3,1, 16'h0002));
    // freeze outranks a pending load-use, which then stalls once released
    step(0, 15,0,16, 1,0,0, 0,1, E(0,0,0, 6,0,15,1,1, 6,1, 5,1, 16'h0002));
    step(0, 15,0,16, 1,0,0, 0,0, E(0,0,1, 6,0,15,1,1, 6,1, 5,1, 16'h0002));
    step(0, 15,0,16, 1,0,0, 0,0, E(1,1,0, 0,0,0,0,0, 15,1, 6,1, 16'h0003));
    // preload counter near saturation, then self-dependent loads stall repeatedly
    step(0, 20,0,20, 1,1,0, 0,0, E(1,1,0, 15,0,16,1,0, 0,0, 15,1, 16'hFFFE));
    force dut.stall_cnt_q = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    step(0, 20,0,20, 1,1,0, 0,0, E(0,0,1, 20,0,20,1,1, 16,1, 0,0, 16'hFFFE));
    step(0, 20,0,20, 1,1,0, 0,0, E(1,1,0, 0,0,0,0,0, 20,1, 16,1, 16'hFFFF));
    step(0, 20,0,20, 1,1,0, 0,0, E(0,0,1, 20,0,20,1,1, 0,0, 20,1, 16'hFFFF));
    step(0, 20,0,20, 1,1,0, 0,0, E(1,1,0, 0,0,0,0,0, 20,1, 0,0, 16'hFFFF));
    // reset raised mid-cycle while a load-use is pending: clears without an edge
    step(1, 20,0,20, 1,1,0, 0,0, E(1,1,0, 0,0,0,0,0, 0,0, 0,0, 16'h0000));
    step(0, 20,0,20, 1,1,0, 0,0, E(1,1,0, 0,0,0,0,0, 0,0, 0,0, 16'h0000));
    // first edge after release advances normally
    step(0, 20,0,20, 1,1,0, 0,0, E(0,0,1, 20,0,20,1,1, 0,0, 0,0, 16'h0000));
    step(0, 0,0,0,   0,0,0, 0,0, E(1,1,0, 0,0,0,0,0, 20,1, 0,0, 16'h0001));

    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
